// File: rtl/pwr_seq_arb.sv
// Power-shut-off transition scheduler: grants one domain at a time a sleep or
// wake transition, round-robin, with a completion timeout and a guard gap.
module pwr_seq_arb #(
  parameter int NUM_DOM = 4,
  parameter int GAP_CYC = 8,
  parameter int TO_CYC  = 256,
  parameter int CNT_W   = 9,
  localparam int IDX_W  = $clog2(NUM_DOM)
) (
  input  logic               pclk,
  input  logic               prst,
  input  logic [NUM_DOM-1:0] sw_req,
  input  logic [NUM_DOM-1:0] dom_pwr_on,
  input  logic [NUM_DOM-1:0] dom_clr_status,
  input  logic [NUM_DOM-1:0] err_clr,
  output logic [NUM_DOM-1:0] l1_req,
  output logic [NUM_DOM-1:0] dom_off,
  output logic               busy,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               done_pulse,
  output logic [NUM_DOM-1:0] err_timeout
);

  typedef enum logic [1:0] {IDLE, SLEEP_WAIT, WAKE_WAIT, GAP} state_t;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYC == 0) ? '0 : CNT_W'(GAP_CYC - 1);
  localparam state_t           POST     = (GAP_CYC == 0) ? IDLE : GAP;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_DOM-1:0] l1_q, l1_d, off_q, off_d, err_q, err_d;
  logic [IDX_W-1:0]   grant_q, grant_d, rr_q, rr_d;
  logic               done_q, done_d;

  logic [NUM_DOM-1:0] pending;
  logic [IDX_W:0]     probe;
  logic [IDX_W-1:0]   sel;
  logic               found;
  logic               complete;

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      l1_q    <= '0;
      off_q   <= '0;
      err_q   <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l1_q    <= l1_d;
      off_q   <= off_d;
      err_q   <= err_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    l1_d     = l1_q;
    off_d    = off_q;
    err_d    = err_q & ~err_clr;
    grant_d  = grant_q;
    rr_d     = rr_q;
    done_d   = 1'b0;
    pending  = (sw_req ^ l1_q) & ~err_q;
    probe    = '0;
    sel      = '0;
    found    = 1'b0;
    complete = 1'b0;

    case (state_q)
      IDLE: begin
        // First pending domain at or above rr_q, wrapping modulo NUM_DOM
        for (int k = 0; k < NUM_DOM; k++) begin
          probe = {1'b0, rr_q} + (IDX_W+1)'(k);
          if (probe >= (IDX_W+1)'(NUM_DOM))
            probe = probe - (IDX_W+1)'(NUM_DOM);
          if (!found && pending[probe[IDX_W-1:0]]) begin
            found = 1'b1;
            sel   = probe[IDX_W-1:0];
          end
        end
        if (found) begin
          grant_d   = sel;
          l1_d[sel] = sw_req[sel];
          rr_d      = (sel == IDX_W'(NUM_DOM - 1)) ? '0 : sel + IDX_W'(1);
          cnt_d     = '0;
          state_d   = sw_req[sel] ? SLEEP_WAIT : WAKE_WAIT;
        end
      end
      SLEEP_WAIT, WAKE_WAIT: begin
        cnt_d    = cnt_q + CNT_W'(1);
        complete = (state_q == SLEEP_WAIT) ? ~dom_pwr_on[grant_q] : dom_clr_status[grant_q];
        // Completion is checked first so it beats a coincident timeout
        if (complete) begin
          off_d[grant_q] = (state_q == SLEEP_WAIT);
          done_d         = 1'b1;
          cnt_d          = '0;
          state_d        = POST;
        end else if (cnt_q == TO_LAST) begin
          err_d[grant_q] = 1'b1;
          cnt_d          = '0;
          state_d        = POST;
        end
      end
      GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign l1_req      = l1_q;
  assign dom_off     = off_q;
  assign err_timeout = err_q;
  assign grant_idx   = grant_q;
  assign done_pulse  = done_q;
  assign busy        = (state_q != IDLE);

endmodule
